// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | Instruction-fetch initiator: PC, IF/ID register, redirect and stall. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          PC_out,
  input  logic [31:0]          Instruction,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid,
  output logic                 flush_id,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]          r_pc;
  logic [31:0]          r_if_id_pc;
  logic [31:0]          r_if_id_instr;
  logic                 r_if_id_valid;
  logic                 r_misalign;
  logic [CNT_WIDTH-1:0] r_fetch_count;

  logic [31:0]          w_pc_seq;
  logic [31:0]          w_pc_branch;
  logic                 w_branch_misaligned;

  // Targets are forced word aligned; the low bits only feed the sticky error.
  assign w_pc_seq            = r_pc + PC_STEP;
  assign w_pc_branch         = {branch_addr[31:2], 2'b00};
  assign w_branch_misaligned = (branch_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= 32'h0;
      r_if_id_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else if (branch_taken) begin
      // Redirect wins over freeze and squashes the wrong-path word.
      r_pc          <= w_pc_branch;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= 32'h0;
      r_if_id_valid <= 1'b0;
      if (w_branch_misaligned) begin
        r_misalign <= 1'b1;
      end
    end else if (!freeze) begin
      r_pc          <= w_pc_seq;
      r_if_id_pc    <= w_pc_seq;
      r_if_id_instr <= Instruction;
      r_if_id_valid <= 1'b1;
      r_fetch_count <= r_fetch_count + c_cnt_one;
    end
  end

  assign PC_out       = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_valid  = r_if_id_valid;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;
  assign flush_id     = branch_taken;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch initiator for the 5-stage ARM-subset pipeline.
- Owns the program counter and drives it to the combinational instruction ROM.
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard freeze and EXE-stage branch redirect, and keeps a fetch counter for program-level verification.

Parameters:
- RESET_PC, 0, PC value loaded on reset (byte address, word aligned).
- PC_STEP, 4, sequential PC increment in bytes.
- CNT_WIDTH, 32, width of the fetch counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- freeze  input  1  hazard-unit stall; hold PC and IF/ID.
- branch_taken  input  1  EXE-stage branch resolved taken this cycle.
- branch_addr  input  32  branch target byte address.
- PC_out  output  32  current PC to instruction memory.
- Instruction  input  32  word returned combinationally by instruction memory for PC_out.
- if_id_pc  output  32  registered PC+PC_STEP of the captured instruction.
- if_id_instr  output  32  registered instruction.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- flush_id  output  1  combinational copy of branch_taken, used to kill the ID/EX entry.
- misalign_err  output  1  sticky: a branch target had addr[1:0] != 0.
- fetch_count  output  CNT_WIDTH  number of instructions captured into IF/ID.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle):
  - PC_out=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0, misalign_err=0, fetch_count=0.
  - Reset mid-operation discards everything in flight; the first fetch after release is RESET_PC.
- Fetch latency: the memory word is valid the same cycle as PC_out. It appears on if_id_instr one edge later, giving 1-cycle IF latency.
- Per-edge priority (highest first):
  - branch_taken=1:
    - PC_out <= {branch_addr[31:2],2'b00}.
    - if_id_instr <= 0, if_id_pc <= 0, if_id_valid <= 0 (the wrong-path word is squashed).
    - fetch_count unchanged.
    - If branch_addr[1:0]!=0, set misalign_err (sticky until reset).
    - Branch overrides freeze in the same cycle.
  - freeze=1 (no branch): PC_out, if_id_*, and fetch_count all hold.
  - Otherwise:
    - PC_out <= PC_out+PC_STEP.
    - if_id_instr <= Instruction, if_id_pc <= PC_out+PC_STEP, if_id_valid <= 1.
    - fetch_count <= fetch_count+1.
- Arithmetic:
  - PC addition is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0 with no flag.
  - fetch_count wraps modulo 2^CNT_WIDTH.
- flush_id equals branch_taken combinationally. It is not registered and has no reset dependency beyond its input.
- An all-zero Instruction word is a legal instruction: it is captured with valid=1 and no special handling.
- A branch to the current PC (self-loop) is treated as a normal redirect. The pipeline keeps refetching the same word.
- X/undefined inputs are not required to be tolerated. The bench drives all inputs to known values after reset.

Test Plan:
- Reset then release with freeze=0, branch_taken=0, ROM loaded with the bring-up program:
  - After edge 1: PC_out=4, if_id_instr=0xE3A00014, if_id_pc=4, valid=1, fetch_count=1.
  - After edge 2: if_id_instr=0xE3A01A01, if_id_pc=8.
- With PC_out=12, assert freeze for 3 cycles: PC_out stays 12, IF/ID and fetch_count unchanged. On release the next edge captures word 12 with if_id_pc=16.
- With PC_out=152, assert branch_taken with branch_addr=116 together with freeze=1:
  - flush_id=1 that cycle.
  - Next edge: PC_out=116, if_id_valid=0, if_id_instr=0, count unchanged.
  - Following edge: valid=1, if_id_pc=120.
- branch_addr=0x00000042: PC_out becomes 0x40 and misalign_err=1. It stays 1 after further normal fetches until rst_n=0.
- Drive rst_n low asynchronously mid-cycle while PC_out=60 and valid=1: outputs reset immediately without waiting for a clock edge, and fetch restarts at RESET_PC.
- Force PC near the top via branch_addr=0xFFFFFFFC: the next normal edge gives PC_out=0 and if_id_pc=0.
